// File: rtl/pc060ha_mailbox_flags.sv
// Writer-to-reader mailbox: per-channel data latch, full flag and optional sticky overrun.
// Define PC060HA_MAILBOX_OVERRUN_EN to drop writes into full channels and record OVR.
module pc060ha_mailbox_flags #(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 4
) (
   input  logic                CLK,
   input  logic                RESETTICK,
   input  logic                M_WR,
   input  logic [ADDR_W-1:0]   M_ADDR,
   input  logic [DATA_W-1:0]   M_DIN,
   input  logic                S_RD,
   input  logic [ADDR_W-1:0]   S_ADDR,
   input  logic                S_CLRALL,
   input  logic [CHANNELS-1:0] IRQ_MASK,
   output logic [DATA_W-1:0]   S_DOUT,
   output logic [CHANNELS-1:0] FLAGS,
   output logic [CHANNELS-1:0] OVR,
   output logic                IRQ
);

   logic                wr_q;
   logic                rd_q;
   logic                wr_ev;
   logic                rd_ev;
   logic [CHANNELS-1:0] set_vec;
   logic [CHANNELS-1:0] clr_vec;
   logic [CHANNELS-1:0] load_vec;
   logic [CHANNELS-1:0] flags_nxt;
   logic [DATA_W-1:0]   data [CHANNELS];

   // Edge-detect registers reset high so a strobe held across reset release is not an event.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RESETTICK) begin
      if (RESETTICK) begin
         wr_q <= 1'b1;
         rd_q <= 1'b1;
      end else begin
         wr_q <= M_WR;
         rd_q <= S_RD;
      end
   end

   assign wr_ev = M_WR & ~wr_q;
   assign rd_ev = S_RD & ~rd_q;

   // Out-of-range addresses match no channel, so those events fall away naturally.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         set_vec[c] = wr_ev && (M_ADDR == ADDR_W'(c));
         clr_vec[c] = rd_ev && (S_ADDR == ADDR_W'(c));
      end
   end

`ifdef PC060HA_MAILBOX_OVERRUN_EN
   logic [CHANNELS-1:0] drop_vec;
   logic [CHANNELS-1:0] ovr_q;

   // A same-cycle read of the channel frees it, so that write is accepted.
   assign drop_vec = set_vec & FLAGS & ~clr_vec;
   assign load_vec = set_vec & ~drop_vec;

   always_ff @(posedge CLK or posedge RESETTICK) begin
      if (RESETTICK)
         ovr_q <= '0;
      else if (S_CLRALL)
         ovr_q <= '0;
      else
         ovr_q <= ovr_q | drop_vec;
   end

   assign OVR = ovr_q;
`else
   assign load_vec = set_vec;
   assign OVR      = '0;
`endif

   // Set wins over a coincident read; clear-all overrides both.
   assign flags_nxt = S_CLRALL ? '0 : ((FLAGS & ~clr_vec) | load_vec);

   always_ff @(posedge CLK or posedge RESETTICK) begin
      if (RESETTICK)
         FLAGS <= '0;
      else
         FLAGS <= flags_nxt;
   end

   // NOTE: the data latches are reset too; the reader must see zeros after reset, not stale values.
   always_ff @(posedge CLK or posedge RESETTICK) begin
      if (RESETTICK) begin
         for (int c = 0; c < CHANNELS; c++)
            data[c] <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++)
            if (load_vec[c])
               data[c] <= M_DIN;
      end
   end

   // NOTE: S_DOUT gets a default before the loop so unmatched addresses cannot infer a latch.
   always_comb begin
      S_DOUT = '0;
      for (int c = 0; c < CHANNELS; c++)
         if (S_ADDR == ADDR_W'(c))
            S_DOUT = data[c];
   end

   assign IRQ = |(FLAGS & IRQ_MASK);

endmodule

// File: tb/tb_pc060ha_mailbox_flags.sv
// Directed bench for pc060ha_mailbox_flags: expectations queued at stimulus, popped at sampling.
// A second instance with CHANNELS=3 covers the out-of-range address case.
module tb_pc060ha_mailbox_flags;

   logic       clk;
   logic       rst;
   logic       m_wr, s_rd, s_clrall;
   logic [1:0] m_addr, s_addr;
   logic [3:0] m_din, irq_mask;
   logic [3:0] dout, flags, ovr;
   logic       irq;

   logic       m_wr3, s_rd3, s_clrall3;
   logic [1:0] m_addr3, s_addr3;
   logic [3:0] m_din3, dout3;
   logic [2:0] irq_mask3, flags3, ovr3;
   logic       irq3;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t sb_q[$];

   pc060ha_mailbox_flags #(.CHANNELS(4), .ADDR_W(2), .DATA_W(4)) u_dut (
      .CLK(clk), .RESETTICK(rst), .M_WR(m_wr), .M_ADDR(m_addr), .M_DIN(m_din),
      .S_RD(s_rd), .S_ADDR(s_addr), .S_CLRALL(s_clrall), .IRQ_MASK(irq_mask),
      .S_DOUT(dout), .FLAGS(flags), .OVR(ovr), .IRQ(irq)
   );

   pc060ha_mailbox_flags #(.CHANNELS(3), .ADDR_W(2), .DATA_W(4)) u_dut3 (
      .CLK(clk), .RESETTICK(rst), .M_WR(m_wr3), .M_ADDR(m_addr3), .M_DIN(m_din3),
      .S_RD(s_rd3), .S_ADDR(s_addr3), .S_CLRALL(s_clrall3), .IRQ_MASK(irq_mask3),
      .S_DOUT(dout3), .FLAGS(flags3), .OVR(ovr3), .IRQ(irq3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "bench timed out");
   end

   task automatic sb_push(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] observed);
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %0h required <queued value>", observed);
      end else begin
         e = sb_q.pop_front();
         assert (observed === e.value) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", e.tag, observed, e.value);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      m_wr = 0; s_rd = 0; s_clrall = 0; m_addr = 0; s_addr = 0; m_din = 0; irq_mask = 0;
      m_wr3 = 0; s_rd3 = 0; s_clrall3 = 0; m_addr3 = 0; s_addr3 = 0; m_din3 = 0; irq_mask3 = 0;
      #2;
      sb_push("rst_flags", 0); sb_push("rst_ovr", 0); sb_push("rst_dout", 0); sb_push("rst_irq", 0);
      check(flags); check(ovr); check(dout); check(irq);
      step(); step();
      rst = 1'b0;
      step();

      // basic write to channel 2
      m_addr = 2; m_din = 4'hA; m_wr = 1; irq_mask = 4'b0100; s_addr = 2;
      sb_push("wr_flags", 4'b0100); sb_push("wr_dout", 4'hA); sb_push("wr_irq", 1);
      step(); m_wr = 0;
      check(flags); check(dout); check(irq);
      step();

      // read acknowledge
      s_rd = 1;
      sb_push("rd_flags", 0); sb_push("rd_irq", 0); sb_push("rd_dout", 4'hA);
      step(); s_rd = 0;
      check(flags); check(irq); check(dout);
      step();

      // held write strobe produces one event only
      m_addr = 0; m_din = 4'h1; m_wr = 1;
      sb_push("hold_set", 4'b0001);
      step(); check(flags);
      s_addr = 0; s_rd = 1;
      sb_push("hold_clr", 0);
      step(); s_rd = 0; check(flags);
      sb_push("hold_norepeat", 0);
      step(); check(flags);
      m_wr = 0; step();

      // double write to channel 1 without read
      m_addr = 1; m_din = 4'h3; m_wr = 1; step(); m_wr = 0; step();
      m_din = 4'h5; m_wr = 1; step(); m_wr = 0; s_addr = 1;
      sb_push("dbl_flags", 4'b0010);
`ifdef PC060HA_MAILBOX_OVERRUN_EN
      sb_push("dbl_dout", 4'h3); sb_push("dbl_ovr", 4'b0010);
`else
      sb_push("dbl_dout", 4'h5); sb_push("dbl_ovr", 0);
`endif
      #1; check(flags); check(dout); check(ovr);
      step();

      // clear all flags and overrun bits
      s_clrall = 1;
      sb_push("clr_flags", 0); sb_push("clr_ovr", 0);
      step(); s_clrall = 0;
      check(flags); check(ovr);

      // same-cycle write and read on a full channel 0: set wins
      m_addr = 0; m_din = 4'h9; m_wr = 1; step(); m_wr = 0; step();
      m_din = 4'h7; m_wr = 1; s_addr = 0; s_rd = 1;
      sb_push("same_flags", 4'b0001); sb_push("same_dout", 4'h7); sb_push("same_ovr", 0);
      step(); m_wr = 0; s_rd = 0;
      check(flags); check(dout); check(ovr);
      step();

      // write ch3 and read ch0 in the same cycle
      m_addr = 3; m_din = 4'hC; m_wr = 1; s_addr = 0; s_rd = 1;
      sb_push("diff_flags", 4'b1000);
      step(); m_wr = 0; s_rd = 0;
      check(flags);
      s_addr = 3; #1;
      sb_push("diff_dout", 4'hC); check(dout);
      step();

      // clear-all with coincident write: flags cleared, data still written
      s_clrall = 1; m_addr = 2; m_din = 4'h6; m_wr = 1; s_addr = 2;
      sb_push("clrwr_flags", 0); sb_push("clrwr_dout", 4'h6);
      step(); s_clrall = 0; m_wr = 0;
      check(flags); check(dout);
      step();

      // out-of-range address on the 3-channel instance
      m_addr3 = 3; m_din3 = 4'hF; m_wr3 = 1; s_addr3 = 3;
      sb_push("oor_flags", 0); sb_push("oor_dout", 0);
      step(); m_wr3 = 0;
      check(flags3); check(dout3);
      step();
      m_addr3 = 2; m_din3 = 4'hE; m_wr3 = 1;
      sb_push("oor_in_flags", 3'b100);
      step(); m_wr3 = 0; check(flags3);
      s_addr3 = 2; #1; sb_push("oor_in_dout", 4'hE); check(dout3);
      s_addr3 = 3; #1; sb_push("oor_dout2", 0); check(dout3);
      step();

      // asynchronous reset with write strobe held high across release
      m_addr = 1; m_din = 4'hF; m_wr = 1; s_addr = 2; rst = 1;
      #1;
      sb_push("arst_flags", 0); sb_push("arst_dout", 0); sb_push("arst_flags3", 0);
      check(flags); check(dout); check(flags3);
      step(); step();
      rst = 0;
      step(); step();
      sb_push("held_flags", 0); check(flags);
      m_wr = 0; step();
      m_wr = 1;
      sb_push("fresh_flags", 4'b0010);
      step(); m_wr = 0; check(flags);
      s_addr = 1; #1;
      sb_push("fresh_dout", 4'hF); check(dout);
      step();

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sb_leftover: observed %0d entries required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
